// File: rtl/dmem_line_adapter.sv
// ---------------------------------------------------------------------------
// dmem_line_adapter : one-line buffer bridging 32-bit load/store requests to
// 64-bit burst memory. Optional macro DMEM_LINE_BUF_EN enables hit service.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_line_adapter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int LINE_BITS = BURST_LEN * 64;
  localparam int OFF_W     = $clog2(BURST_LEN * 8);
  localparam int BEAT_W    = $clog2(BURST_LEN);
  localparam int WORD_W    = OFF_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_REQ  = 3'd1,
    FILL_WAIT = 3'd2,
    WB        = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [31-OFF_W:0]    tag_q, tag_d;
  logic [BEAT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  logic              is_wr, req, hit, last, merge;
  logic [31-OFF_W:0] req_tag;
  logic [WORD_W-1:0] word_idx;
  logic [31:0]       shifted;
  logic [31:0]       line_addr;

  assign is_wr     = |dmem_wmask;
  assign req       = is_wr | dmem_rmask;
  assign req_tag   = dmem_addr[31:OFF_W];
  assign word_idx  = dmem_addr[OFF_W-1:2];
  assign shifted   = dmem_wdata << {dmem_addr[1:0], 3'b000};
  assign line_addr = {req_tag, {OFF_W{1'b0}}};
  assign last      = (cnt_q == LAST_BEAT);

`ifdef DMEM_LINE_BUF_EN
  assign hit = valid_q && (tag_q == req_tag);
`else
  // Buffer is only a fill/merge staging area here; every request refills.
  logic unused_buf_state;
  assign unused_buf_state = ^{valid_q, tag_q};
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    merge      = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_d = is_wr ? WB : RESP;
            merge   = is_wr;
          end else begin
            state_d = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = line_addr;
        if (bmem_ready) begin
          state_d = FILL_WAIT;
          cnt_d   = '0;
        end
      end
      FILL_WAIT: begin
        if (bmem_rvalid) begin
          line_d[{cnt_q, 6'b0} +: 64] = bmem_rdata;
          cnt_d = last ? '0 : cnt_q + BEAT_W'(1);
          if (last) begin
            valid_d = 1'b1;
            tag_d   = req_tag;
            state_d = is_wr ? WB : RESP;
            merge   = is_wr;
          end
        end
      end
      WB: begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr;
        bmem_wdata = line_q[{cnt_q, 6'b0} +: 64];
        if (bmem_ready) begin
          cnt_d = last ? '0 : cnt_q + BEAT_W'(1);
          if (last) state_d = RESP;
        end
      end
      RESP: begin
        dmem_resp  = 1'b1;
        dmem_rdata = line_q[{word_idx, 5'b0} +: 32];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Store merge lands on top of any beat captured this same cycle.
    if (merge) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wmask[i]) line_d[{word_idx, 2'(i), 3'b000} +: 8] = shifted[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire
